// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used by the serial arithmetic datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: LSB-first through one full-adder cell and a carry flop,
// W+1 cycles from accepted start to a one-cycle done pulse.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   sa_q, sa_d;
    logic [W-1:0]   sb_q, sb_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           fa_s, fa_c;

    full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d         = sa_q >> 1;
                sb_d         = sb_q >> 1;
                // Each new sum bit enters at the MSB so the LSB lands at bit 0 after W shifts.
                sum_d        = sum_q >> 1;
                sum_d[W-1]   = fa_s;
                carry_d      = fa_c;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard on done, corner sequences.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       busy, done, cout;
    logic [3:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_count = 0;
    int last_done  = -1;
    bit period_chk = 1'b0;
    logic [4:0] sb_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;
    vec_t vecs[6];

    serial_adder #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got sum=%0h cout=%0b with nothing pending", sum, cout);
            end else begin
                logic [4:0] e;
                e = sb_q.pop_front();
                if ({cout, sum} !== e) begin
                    n_fail++;
                    $display("FAIL result: got {cout,sum}=%0h expected %0h", {cout, sum}, e);
                end
            end
            if (period_chk && last_done >= 0) begin
                n_checks++;
                if (cyc - last_done != 6) begin
                    n_fail++;
                    $display("FAIL done_period: got %0d expected 6", cyc - last_done);
                end
            end
            last_done = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 1;
        busy_cyc = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (done) break;
            if (busy) busy_cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] exp);
        int lat, bc;
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        sb_q.push_back(exp);
        a = ~va; b = ~vb;
        wait_done(lat, bc);
        check("latency", lat, 5);
        check("busy_cycles", bc, 4);
        step();
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int lat, bc, base;
        vecs[0] = '{4'h5, 4'h3, 4'h8, 1'b0};
        vecs[1] = '{4'hF, 4'h1, 4'h0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, 4'hE, 1'b1};
        vecs[3] = '{4'h0, 4'h0, 4'h0, 1'b0};
        vecs[4] = '{4'hA, 4'h5, 4'hF, 1'b0};
        vecs[5] = '{4'h8, 4'h8, 4'h0, 1'b1};

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        // Table-driven operations
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, {vecs[i].exp_cout, vecs[i].exp_sum});

        // Result held in IDLE
        step(); step();
        check("hold_sum", sum, 4'h0);
        check("hold_cout", cout, 1'b1);

        // Start re-pulsed mid-RUN is ignored
        base = done_count;
        a = 4'h6; b = 4'h7; start = 1'b1;
        step();
        start = 1'b0;
        sb_q.push_back(5'h0D);
        step();
        a = 4'hF; b = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bc);
        for (int i = 0; i < 6; i++) step();
        check("single_done", done_count - base, 1);
        check("busy_after_ignored", busy, 0);

        // Reset mid-RUN aborts without done
        base = done_count;
        a = 4'h9; b = 4'h9; start = 1'b1;
        step();
        start = 1'b0;
        check("abort_busy_run", busy, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        for (int i = 0; i < 8; i++) step();
        check("abort_no_done", done_count - base, 0);
        run_op(4'h9, 4'h9, 5'h12);

        // Exhaustive with start held high
        period_chk = 1'b1;
        last_done = -1;
        start = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [4:0] e;
                bit seen;
                e = 5'(x + y);
                a = 4'(x); b = 4'(y);
                seen = 1'b0;
                for (int t = 0; t < 4; t++) begin
                    step();
                    if (busy) begin seen = 1'b1; break; end
                end
                if (!seen) check("accept_timeout", 0, 1);
                sb_q.push_back(e);
                a = 4'($urandom); b = 4'($urandom);
                seen = 1'b0;
                for (int t = 0; t < 10; t++) begin
                    step();
                    if (done) begin seen = 1'b0; seen = 1'b1; break; end
                end
                if (!seen) check("done_timeout", 0, 1);
            end
        end
        start = 1'b0;
        period_chk = 1'b0;
        step(); step();
        check("sb_empty", sb_q.size(), 0);

        // W=1 instance
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        step();
        check("w1_done_a", done1, 1);
        check("w1_sum_a", sum1, 1);
        check("w1_cout_a", cout1, 0);
        step();
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        check("w1_done_b", done1, 1);
        check("w1_sum_b", sum1, 0);
        check("w1_cout_b", cout1, 1);
        step();
        check("w1_done_clear", done1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
